// File: rtl/cc_miss_req_sequencer.sv
// cc_miss_req_sequencer: accepts cache misses, pushes the miss FIFO, issues AR bursts, tracks refills.
// Optional checker build: define CC_MISS_SEQ_CHK_EN to add err_o and R beat counting.
module cc_miss_req_sequencer #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_req_i,
    input  logic [31:0]      miss_addr_i,
    output logic             miss_ack_o,
    input  logic             miss_addr_fifo_full_i,
    output logic             miss_addr_fifo_wren_o,
    output logic [31:0]      miss_addr_fifo_wdata_o,
    output logic             mem_arvalid_o,
    input  logic             mem_arready_i,
    output logic [31:0]      mem_araddr_o,
    output logic [3:0]       mem_arlen_o,
    output logic [2:0]       mem_arsize_o,
    output logic [1:0]       mem_arburst_o,
    input  logic             mem_rvalid_i,
    input  logic             mem_rready_i,
    input  logic             mem_rlast_i,
`ifdef CC_MISS_SEQ_CHK_EN
    output logic             err_o,
`endif
    output logic [CNT_W-1:0] outstanding_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             retire;
    logic [CNT_W-1:0] out_q;

    assign retire = mem_rvalid_i && mem_rready_i && mem_rlast_i;

    // Next state: one AR per accepted miss, no new accept while the AR is pending.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_req_i && !miss_addr_fifo_full_i && (out_q < MAX_CNT)) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_arready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the miss: aligned AR address, raw address and one-cycle FIFO push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_araddr_o           <= '0;
            miss_addr_fifo_wren_o  <= 1'b0;
            miss_addr_fifo_wdata_o <= '0;
        end else begin
            miss_addr_fifo_wren_o <= accept;
            if (accept) begin
                mem_araddr_o           <= {miss_addr_i[31:3], 3'b000};
                miss_addr_fifo_wdata_o <= miss_addr_i;
            end
        end
    end

    // Outstanding refills: +1 on accept, -1 on RLAST, saturating at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            unique case ({accept, retire})
                2'b10: out_q <= out_q + CNT_W'(1);
                2'b01: begin
                    if (out_q != '0) begin
                        out_q <= out_q - CNT_W'(1);
                    end
                end
                default: out_q <= out_q;
            endcase
        end
    end

`ifdef CC_MISS_SEQ_CHK_EN
    logic [2:0] beat_q;
    logic       err_q;

    // Burst checker: counts R beats and flags short/long or unexpected bursts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (mem_rvalid_i && mem_rready_i) begin
                beat_q <= mem_rlast_i ? 3'd0 : beat_q + 3'd1;
            end
            if (retire && ((beat_q != 3'd7) || (out_q == '0))) begin
                err_q <= 1'b1;
            end
            if (accept && (out_q == MAX_CNT)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`endif

    assign miss_ack_o    = accept;
    assign mem_arvalid_o = (state_q == ISSUE);
    assign mem_arlen_o   = 4'd7;
    assign mem_arsize_o  = 3'b011;
    assign mem_arburst_o = 2'b10;
    assign outstanding_o = out_q;
    assign busy_o        = (state_q != IDLE) || (out_q != '0);

endmodule
